random_arbiter: RTL and testbench
=================================

# random_arbiter

Shares one latched-counter random source between up to NUM_REQ game blocks that need random values, such as spawn positions and enemy timing. It arbitrates requests round-robin and drives the source's rising-edge trigger. It captures and checks the returned value, then delivers it to the winner with a one-cycle grant pulse. It sits between the keyboard/random source and the game-logic requesters.

## Interface
- NUM_REQ, 4: number of requesters (2..8)
- SIZE_BITS, 10: width of random value
- MIN_VAL, 0: lowest legal value
- MAX_VAL, 479: highest legal value
- NO_REPEAT, 1: 1 = reject a value equal to the previously delivered value
- MAX_RETRY, 3: extra source fires allowed per request before forced delivery
- clk  in  1  system clock; single clock domain
- resetN  in  1  asynchronous, active-low reset
- req  in  NUM_REQ  level request per requester; held until its grant
- src_dout  in  SIZE_BITS  value from the random source, registered in the source
- src_rise  out  1  trigger to the source; the source latches on the 0->1 transition
- gnt  out  NUM_REQ  one-hot grant, one-cycle pulse
- rand_valid  out  1  one-cycle pulse, coincident with gnt
- rand_data  out  SIZE_BITS  delivered value; held until the next delivery
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, FIRE, WAIT, CHECK, GRANT.
- IDLE: if any req bit is set, select the winner and go to FIRE. Otherwise stay in IDLE.
  - The winner is the first set bit at or after rr_ptr, wrapping modulo NUM_REQ.
  - Clear retry_cnt when a winner is selected.
- FIRE: src_rise=1 for exactly this cycle. Next state is WAIT.
- WAIT: src_rise=0. src_dout is valid this cycle; capture it into cap_val. Next state is CHECK.
- CHECK: src_rise=0. Evaluate bad = out_of_range OR (NO_REPEAT AND last_ok AND cap_val==last_val).
  - out_of_range means cap_val<MIN_VAL or cap_val>MAX_VAL (unsigned compare).
  - If bad and retry_cnt<MAX_RETRY: increment retry_cnt and go to FIRE.
  - Otherwise go to GRANT. The value delivered is cap_val clamped to [MIN_VAL,MAX_VAL]. A forced repeat is allowed.
- GRANT: gnt[winner]=1, rand_valid=1, rand_data=delivered value.
  - Update last_val=delivered value and set last_ok=1.
  - Set rr_ptr=(winner+1) mod NUM_REQ.
  - Next state is IDLE.
- The winner is latched in IDLE. If the winner drops req after that, the sequence still completes and grants it.
- A requester still asserting req in the cycle after its gnt is treated as a new request.
- Requests arriving during busy wait their turn. There is no queueing beyond the req level.

## Timing
- Reset values:
  - State IDLE.
  - gnt=0, rand_valid=0, src_rise=0, busy=0.
  - rand_data=MIN_VAL, rr_ptr=0, last_ok=0, retry_cnt=0.
- All outputs are registered.
- Latency with no retry: req sampled high in IDLE at cycle 0. FIRE at cycle 1, WAIT at cycle 2, CHECK at cycle 3, gnt/rand_valid at cycle 4. Back in IDLE at cycle 5.
- Each retry adds 3 cycles (FIRE, WAIT, CHECK). Worst-case latency is 4+3*MAX_RETRY cycles.
- src_rise is low for at least 2 cycles between fires, so every FIRE produces a fresh source edge.
- Reset asserted mid-sequence: all registers return to their reset values immediately, with no grant issued. Requesters re-request after reset.
- A simultaneous request from the current winner and others does not starve anyone. Maximum wait is NUM_REQ grants.

## Test plan
- Single request:
  - Stimulus: source modelled as the latched free-running counter 0..479; req=0001 held.
  - Required: src_rise pulses at cycle 1; gnt=0001 and rand_valid at cycle 4; rand_data equals the counter value latched at the cycle-1 edge; busy high in cycles 1..4.
- Round-robin:
  - Stimulus: req=1111 held throughout.
  - Required: grants in order 0001, 0010, 0100, 1000, 0001, spaced 5 cycles apart.
- Repeat rejection:
  - Stimulus: source forced to 17, 17, 42.
  - Required: first request gets 17. Second request fires twice and receives 42 at 7 cycles latency.
- Retry exhaustion:
  - Stimulus: source stuck at 600 with MAX_RETRY=3.
  - Required: 4 fires, then delivery of 479 (clamped) at cycle 13.
- Mid-sequence reset:
  - Stimulus: assert resetN=0 in WAIT.
  - Required: gnt, rand_valid, src_rise and busy are 0 immediately; rand_data=0; after release, a req=0100 is granted first (rr_ptr=0 scan still selects bit 2).
- Dropped request:
  - Stimulus: requester 1 deasserts req in FIRE.
  - Required: gnt=0010 still pulses at cycle 4; rr_ptr becomes 2.

Source files
------------

// File: rtl/random_arbiter.sv
// random_arbiter: round-robin front end for one shared latched-counter random
// source. A requester wins, the source is fired, the returned value is checked
// for range and repetition (re-firing up to MAX_RETRY times), and the delivered
// value goes to the winner together with a one-cycle grant pulse.
//
// Handshake: req is a level held by a requester until it sees its gnt bit.
// gnt and rand_valid pulse together for exactly one cycle; rand_data is valid
// in that cycle and holds until the next delivery. A req still high in the
// cycle after its gnt counts as a fresh request.
module random_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int SIZE_BITS = 10,
    parameter int MIN_VAL   = 0,
    parameter int MAX_VAL   = 479,
    parameter int NO_REPEAT = 1,
    parameter int MAX_RETRY = 3
) (
    input  logic                 clk,
    input  logic                 resetN,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [SIZE_BITS-1:0] src_dout,
    output logic                 src_rise,
    output logic [NUM_REQ-1:0]   gnt,
    output logic                 rand_valid,
    output logic [SIZE_BITS-1:0] rand_data,
    output logic                 busy,
    output logic [2:0]           state_dbg
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int SUM_W = IDX_W + 1;
    localparam int RTY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    localparam logic [SIZE_BITS-1:0] MIN_V    = SIZE_BITS'(MIN_VAL);
    localparam logic [SIZE_BITS-1:0] MAX_V    = SIZE_BITS'(MAX_VAL);
    localparam logic [RTY_W-1:0]     RTY_LIM  = RTY_W'(MAX_RETRY);
    localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(NUM_REQ - 1);
    localparam logic [SUM_W-1:0]     NUM_SUM  = SUM_W'(NUM_REQ);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FIRE  = 3'd1,
        S_WAIT  = 3'd2,
        S_CHECK = 3'd3,
        S_GRANT = 3'd4
    } state_t;

    state_t               state_q;
    logic [IDX_W-1:0]     win_q;
    logic [IDX_W-1:0]     rr_ptr_q;
    logic [RTY_W-1:0]     retry_cnt_q;
    logic [SIZE_BITS-1:0] cap_val_q;
    logic [SIZE_BITS-1:0] last_val_q;
    logic                 last_ok_q;
    logic                 src_rise_q;
    logic [NUM_REQ-1:0]   gnt_q;
    logic                 rand_valid_q;
    logic [SIZE_BITS-1:0] rand_data_q;
    logic                 busy_q;

    // Combinational helpers feeding the FSM.
    logic                 win_found_d;
    logic [IDX_W-1:0]     win_idx_d;
    logic [SUM_W-1:0]     scan_sum;
    logic [IDX_W-1:0]     scan_idx;
    logic                 out_low_d;
    logic                 out_high_d;
    logic                 repeat_d;
    logic                 bad_d;
    logic                 retry_ok_d;
    logic [SIZE_BITS-1:0] deliver_d;
    logic [NUM_REQ-1:0]   win_onehot_d;
    logic [IDX_W-1:0]     rr_next_d;

    // Round-robin scan: first set req bit at or after rr_ptr, wrapping.
    always_comb begin
        win_found_d = 1'b0;
        win_idx_d   = rr_ptr_q;
        scan_sum    = '0;
        scan_idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_sum = {1'b0, rr_ptr_q} + SUM_W'(k);
            if (scan_sum >= NUM_SUM) begin
                scan_sum = scan_sum - NUM_SUM;
            end
            scan_idx = scan_sum[IDX_W-1:0];
            if (!win_found_d && req[scan_idx]) begin
                win_found_d = 1'b1;
                win_idx_d   = scan_idx;
            end
        end
    end

    // A zero lower bound can never be undershot, so skip that compare entirely.
    generate
        if (MIN_VAL == 0) begin : g_low_zero
            assign out_low_d = 1'b0;
        end else begin : g_low_cmp
            assign out_low_d = (cap_val_q < MIN_V);
        end
    endgenerate

    assign out_high_d   = (cap_val_q > MAX_V);
    assign repeat_d     = (NO_REPEAT != 0) && last_ok_q && (cap_val_q == last_val_q);
    assign bad_d        = out_low_d || out_high_d || repeat_d;
    assign retry_ok_d   = (retry_cnt_q < RTY_LIM);
    assign deliver_d    = out_low_d  ? MIN_V :
                          out_high_d ? MAX_V : cap_val_q;
    assign win_onehot_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_q;
    assign rr_next_d    = (win_q == LAST_IDX) ? '0 : win_q + 1'b1;

    // Sequencer: IDLE -> FIRE -> WAIT -> CHECK -> (FIRE on retry | GRANT) -> IDLE.
    // Every output is set on the transition into the state that owns it.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q      <= S_IDLE;
            win_q        <= '0;
            rr_ptr_q     <= '0;
            retry_cnt_q  <= '0;
            cap_val_q    <= '0;
            last_val_q   <= '0;
            last_ok_q    <= 1'b0;
            src_rise_q   <= 1'b0;
            gnt_q        <= '0;
            rand_valid_q <= 1'b0;
            rand_data_q  <= MIN_V;
            busy_q       <= 1'b0;
        end else begin
            src_rise_q   <= 1'b0;
            gnt_q        <= '0;
            rand_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (win_found_d) begin
                        win_q       <= win_idx_d;
                        retry_cnt_q <= '0;
                        src_rise_q  <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= S_FIRE;
                    end
                end
                S_FIRE: begin
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    cap_val_q <= src_dout;
                    state_q   <= S_CHECK;
                end
                S_CHECK: begin
                    if (bad_d && retry_ok_d) begin
                        retry_cnt_q <= retry_cnt_q + 1'b1;
                        src_rise_q  <= 1'b1;
                        state_q     <= S_FIRE;
                    end else begin
                        gnt_q        <= win_onehot_d;
                        rand_valid_q <= 1'b1;
                        rand_data_q  <= deliver_d;
                        last_val_q   <= deliver_d;
                        last_ok_q    <= 1'b1;
                        rr_ptr_q     <= rr_next_d;
                        state_q      <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign src_rise   = src_rise_q;
    assign gnt        = gnt_q;
    assign rand_valid = rand_valid_q;
    assign rand_data  = rand_data_q;
    assign busy       = busy_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_random_arbiter.sv
// Directed bench for random_arbiter with a behavioural latched-counter source.
module tb_random_arbiter;

    logic       clk;
    logic       resetN;
    logic [3:0] req;
    logic [9:0] src_dout;
    logic       src_rise;
    logic [3:0] gnt;
    logic       rand_valid;
    logic [9:0] rand_data;
    logic       busy;
    logic [2:0] state_dbg;

    int vectors     = 0;
    int miscompares = 0;

    // Source model state.
    logic [9:0] cnt       = '0;
    logic       rise_prev = 1'b0;
    logic [9:0] force_q[$];
    logic       stuck_en  = 1'b0;
    logic [9:0] stuck_val = '0;
    int         fire_cnt  = 0;

    logic [9:0] exp_val;
    logic [3:0] exp_gnt;
    int         fire_start;

    random_arbiter #(
        .NUM_REQ(4), .SIZE_BITS(10), .MIN_VAL(0), .MAX_VAL(479),
        .NO_REPEAT(1), .MAX_RETRY(3)
    ) dut (
        .clk        (clk),
        .resetN     (resetN),
        .req        (req),
        .src_dout   (src_dout),
        .src_rise   (src_rise),
        .gnt        (gnt),
        .rand_valid (rand_valid),
        .rand_data  (rand_data),
        .busy       (busy),
        .state_dbg  (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial src_dout = '0;

    // Free-running 0..479 counter latched into src_dout on a src_rise 0->1 edge;
    // queued forced values take priority, then a stuck value, then the counter.
    always @(posedge clk) begin
        cnt       <= (cnt == 10'd479) ? 10'd0 : cnt + 10'd1;
        rise_prev <= src_rise;
        if (src_rise && !rise_prev) begin
            fire_cnt <= fire_cnt + 1;
            if (force_q.size() > 0) src_dout <= force_q.pop_front();
            else if (stuck_en)      src_dout <= stuck_val;
            else                    src_dout <= cnt;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        resetN = 1'b0;
        req    = '0;
        tick();
        tick();
        resetN = 1'b1;
    endtask

    initial begin
        resetN = 1'b0;
        req    = '0;

        // Reset values.
        #2;
        check("rst_gnt",   gnt,        0);
        check("rst_valid", rand_valid, 0);
        check("rst_rise",  src_rise,   0);
        check("rst_busy",  busy,       0);
        check("rst_data",  rand_data,  0);
        check("rst_state", state_dbg,  0);
        tick();
        tick();
        resetN = 1'b1;

        // Single request: fire at 1, grant at 4, idle at 5.
        check("single_idle_busy", busy, 0);
        req = 4'b0001;
        tick();
        check("single_c1_rise", src_rise, 1);
        check("single_c1_busy", busy, 1);
        check("single_c1_gnt",  gnt, 0);
        exp_val = cnt;
        tick();
        check("single_c2_rise", src_rise, 0);
        check("single_c2_busy", busy, 1);
        tick();
        check("single_c3_valid", rand_valid, 0);
        check("single_c3_busy",  busy, 1);
        tick();
        check("single_c4_gnt",   gnt, 4'b0001);
        check("single_c4_valid", rand_valid, 1);
        check("single_c4_data",  rand_data, exp_val);
        check("single_c4_busy",  busy, 1);
        req = '0;
        tick();
        check("single_c5_gnt",   gnt, 0);
        check("single_c5_valid", rand_valid, 0);
        check("single_c5_busy",  busy, 0);
        check("single_c5_hold",  rand_data, exp_val);

        // Round-robin with all four requesting, grants every 5 cycles.
        do_reset();
        req = 4'b1111;
        for (int c = 1; c <= 24; c++) begin
            tick();
            if (c % 5 == 1) exp_val = cnt;
            exp_gnt = (c % 5 == 4) ? (4'b0001 << ((c / 5) % 4)) : 4'b0000;
            check("rr_gnt", gnt, exp_gnt);
            check("rr_valid", rand_valid, (c % 5 == 4) ? 1 : 0);
            if (c % 5 == 4) check("rr_data", rand_data, exp_val);
        end
        req = '0;
        tick();
        check("rr_end_busy", busy, 0);

        // Repeat rejection: 17 then 17 (rejected) then 42.
        do_reset();
        force_q.push_back(10'd17);
        force_q.push_back(10'd17);
        force_q.push_back(10'd42);
        req = 4'b0001;
        repeat (4) tick();
        check("rep_first_gnt",  gnt, 4'b0001);
        check("rep_first_data", rand_data, 17);
        req = '0;
        tick();
        req = 4'b0010;
        for (int c = 1; c <= 7; c++) begin
            tick();
            check("rep_rise", src_rise, (c == 1 || c == 4) ? 1 : 0);
            check("rep_gnt",  gnt, (c == 7) ? 4'b0010 : 4'b0000);
        end
        check("rep_second_data",  rand_data, 42);
        check("rep_second_valid", rand_valid, 1);
        req = '0;
        tick();

        // Retry exhaustion: stuck at 600, four fires, clamped 479 at cycle 13.
        do_reset();
        stuck_en   = 1'b1;
        stuck_val  = 10'd600;
        fire_start = fire_cnt;
        req = 4'b0001;
        for (int c = 1; c <= 13; c++) begin
            tick();
            check("exh_rise", src_rise, (c == 1 || c == 4 || c == 7 || c == 10) ? 1 : 0);
            check("exh_gnt",  gnt, (c == 13) ? 4'b0001 : 4'b0000);
        end
        check("exh_data",  rand_data, 479);
        check("exh_fires", fire_cnt - fire_start, 4);
        req      = '0;
        stuck_en = 1'b0;
        tick();

        // Mid-sequence reset while in WAIT.
        req = 4'b0001;
        tick();
        tick();
        check("mid_in_wait", state_dbg, 2);
        resetN = 1'b0;
        req    = '0;
        #1;
        check("mid_gnt",   gnt,        0);
        check("mid_valid", rand_valid, 0);
        check("mid_rise",  src_rise,   0);
        check("mid_busy",  busy,       0);
        check("mid_data",  rand_data,  0);
        check("mid_state", state_dbg,  0);
        tick();
        resetN = 1'b1;
        req    = 4'b0100;
        for (int c = 1; c <= 4; c++) begin
            tick();
            check("mid_after_gnt", gnt, (c == 4) ? 4'b0100 : 4'b0000);
        end
        req = '0;
        tick();

        // Dropped request: requester 1 lets go during FIRE, still granted.
        req = 4'b0010;
        tick();
        check("drop_c1_rise", src_rise, 1);
        req = '0;
        tick();
        check("drop_c2_gnt", gnt, 0);
        tick();
        check("drop_c3_gnt", gnt, 0);
        tick();
        check("drop_c4_gnt",   gnt, 4'b0010);
        check("drop_c4_valid", rand_valid, 1);
        tick();
        check("drop_c5_busy", busy, 0);
        req = 4'b1111;
        for (int c = 1; c <= 4; c++) begin
            tick();
            check("drop_next_gnt", gnt, (c == 4) ? 4'b0100 : 4'b0000);
        end
        req = '0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
